// File: rtl/div_sequencer_pkg.sv
// Shared ALU definitions for the multi-cycle divider: widths, state encoding, opcodes.
package div_sequencer_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ITER_COUNT = 32;

  // Divider sequencer states (3-bit encoding)
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEG_A = 3'd1,
    S_NEG_B = 3'd2,
    S_ITER  = 3'd3,
    S_FIX_Q = 3'd4,
    S_FIX_R = 3'd5,
    S_FIN   = 3'd6,
    S_DBZ   = 3'd7
  } div_state_e;

  // ALU divide opcodes: select signedness and which result the ALU forwards
  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_wants_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/result bundle between the execute stage and the divider.
interface div_sequencer_if;
  import div_sequencer_pkg::*;

  logic              start;
  logic              is_signed;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_sequencer_addsub.sv
// Existing 32-bit add/subtract unit; purely combinational, no carry-out.
module div_sequencer_addsub
  import div_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] sum_c_o
);

  // Subtraction as a + ~b + 1
  always_comb begin
    sum_c_o = a_i + (b_i ^ {DATA_W{sub_i}}) + DATA_W'(sub_i);
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider; every arithmetic step goes through one shared adder.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  div_sequencer_if.slave bus
);

  div_state_e        state_q, state_d;
  logic [DATA_W-1:0] dq_q, dq_d;     // dividend in, quotient bits shifted in
  logic [DATA_W-1:0] div_q, div_d;   // divisor magnitude
  logic [DATA_W-1:0] rem_q, rem_d;   // partial remainder
  logic [DATA_W-1:0] quo_q, quo_d;   // published quotient
  logic [DATA_W-1:0] rmd_q, rmd_d;   // published remainder
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sgn_q, sgn_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic [DATA_W-1:0] add_a, add_b, add_sum, shifted;
  logic              add_sub, iter_ok;

  div_sequencer_addsub u_addsub (
    .a_i     (add_a),
    .b_i     (add_b),
    .sub_i   (add_sub),
    .sum_c_o (add_sum)
  );

  // Adder operand steering and the 33-bit trial-subtract outcome
  always_comb begin
    shifted = {rem_q[DATA_W-2:0], dq_q[DATA_W-1]};
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    unique case (state_q)
      S_NEG_A: begin add_b = dq_q;  add_sub = 1'b1; end
      S_NEG_B: begin add_b = div_q; add_sub = 1'b1; end
      S_FIX_Q: begin add_b = dq_q;  add_sub = 1'b1; end
      S_FIX_R: begin add_b = rem_q; add_sub = 1'b1; end
      S_ITER:  begin add_a = shifted; add_b = div_q; add_sub = 1'b1; end
      default: ;
    endcase
    // Bit shifted out of rem makes the trial value >= 2^32, so it always fits
    iter_ok = rem_q[DATA_W-1]
            | (shifted[DATA_W-1] & ~div_q[DATA_W-1])
            | (~(shifted[DATA_W-1] ^ div_q[DATA_W-1]) & ~add_sum[DATA_W-1]);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    // done pulses in the cycle after FIN, once the results have settled
    done_d  = (state_q == S_FIN);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dq_d    = bus.dividend;
          div_d   = bus.divisor;
          sgn_d   = bus.is_signed;
          neg_q_d = bus.is_signed & (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
          neg_r_d = bus.is_signed & bus.dividend[DATA_W-1];
          busy_d  = 1'b1;
          done_d  = 1'b0;
          dbz_d   = 1'b0;
          state_d = (bus.divisor == '0) ? S_DBZ : S_NEG_A;
        end
      end
      S_NEG_A: begin
        if (sgn_q & dq_q[DATA_W-1]) dq_d = add_sum;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        if (sgn_q & div_q[DATA_W-1]) div_d = add_sum;
        cnt_d   = '0;
        rem_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        rem_d = iter_ok ? add_sum : shifted;
        dq_d  = {dq_q[DATA_W-2:0], iter_ok};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_d = S_FIX_Q;
      end
      S_FIX_Q: begin
        quo_d   = neg_q_q ? add_sum : dq_q;
        state_d = S_FIX_R;
      end
      S_FIX_R: begin
        rmd_d   = neg_r_q ? add_sum : rem_q;
        state_d = S_FIN;
      end
      S_DBZ: begin
        quo_d   = 32'hFFFF_FFFF;
        rmd_d   = dq_q;
        dbz_d   = 1'b1;
        state_d = S_FIN;
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dq_q    <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: hand-computed results, latency, start-ignore and reset abort.
module tb_div_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  div_sequencer_if dif ();

  div_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide at edge N, then check latency, results and a single done pulse
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input int elat, input int restart_at);
    int lat;
    int extra;
    @(negedge clk);
    dif.start     = 1'b1;
    dif.is_signed = sgn;
    dif.dividend  = a;
    dif.divisor   = b;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    chk({tag, " busy_after_start"}, 32'(dif.busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      if (k == restart_at) begin
        dif.start     = 1'b1;
        dif.is_signed = ~sgn;
        dif.dividend  = 32'd50;
        dif.divisor   = 32'd3;
      end
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      if (dif.done === 1'b1) lat = k;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " busy_at_done"}, 32'(dif.busy), 32'd0);
    chk({tag, " quotient"}, dif.quotient, eq);
    chk({tag, " remainder"}, dif.remainder, er);
    chk({tag, " div_by_zero"}, 32'(dif.div_by_zero), 32'(edbz));
    extra = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (dif.done !== 1'b0) extra++;
    end
    chk({tag, " extra_done"}, 32'(extra), 32'd0);
    chk({tag, " quotient_held"}, dif.quotient, eq);
  endtask

  initial begin
    int dcount;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    dif.start     = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    #1;
    chk("reset busy", 32'(dif.busy), 32'd0);
    chk("reset done", 32'(dif.done), 32'd0);
    chk("reset quotient", dif.quotient, 32'd0);
    chk("reset remainder", dif.remainder, 32'd0);
    chk("reset dbz", 32'(dif.div_by_zero), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("u100/7",       1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 37, 0);
    run_op("s-7/2",        1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 37, 0);
    run_op("s7/-2",        1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 37, 0);
    run_op("s-100/7",      1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 37, 0);
    run_op("uFFFFFFFF/1",  1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 37, 0);
    run_op("uFFFFFFFF/FE", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32'd1,         1'b0, 37, 0);
    run_op("u5/0",         1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 2,  0);
    run_op("s5/0",         1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 2,  0);
    run_op("s_ovf",        1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 37, 0);
    run_op("restart",      1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 37, 10);

    // Reset mid-ITER: outputs clear at once and no done appears
    @(negedge clk);
    dif.start     = 1'b1;
    dif.is_signed = 1'b0;
    dif.dividend  = 32'd1000;
    dif.divisor   = 32'd3;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(dif.busy), 32'd0);
    chk("abort done", 32'(dif.done), 32'd0);
    chk("abort quotient", dif.quotient, 32'd0);
    chk("abort remainder", dif.remainder, 32'd0);
    chk("abort dbz", 32'(dif.div_by_zero), 32'd0);
    dcount = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (dif.done !== 1'b0) dcount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (dif.done !== 1'b0) dcount++;
    end
    chk("abort no_done", 32'(dcount), 32'd0);

    run_op("after_reset",  1'b1, 32'd1000,      32'd10,        32'd100,       32'd0,         1'b0, 37, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
